// File: rtl/bf2hw_stream_bridge_if.sv
// ----------------------------------------------------------------------------
// bf2hw_stream_bridge_if
// Byte-stream handshake bundle between the UART, the bridge and the kernel
// core.
//   slave  : bridge side (consumes UART RX / core TX, drives UART TX / core RX)
//   master : environment side (UART + core)
// Signals:
//   uart_rx_data/uart_rx_valid     received byte + one-cycle strobe
//   uart_tx_data/uart_tx_write     byte to send + one-cycle write strobe
//   uart_tx_busy                   UART transmitter busy
//   core_rx_valid/core_rx_data     RX head (first-word fall-through)
//   core_rx_take                   pop RX head
//   core_tx_enable/core_tx_data    push byte into TX buffer
//   core_tx_ready                  TX buffer not full
// ----------------------------------------------------------------------------
interface bf2hw_stream_bridge_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] uart_rx_data;
   logic              uart_rx_valid;
   logic [DATA_W-1:0] uart_tx_data;
   logic              uart_tx_write;
   logic              uart_tx_busy;
   logic              core_rx_valid;
   logic [DATA_W-1:0] core_rx_data;
   logic              core_rx_take;
   logic              core_tx_enable;
   logic [DATA_W-1:0] core_tx_data;
   logic              core_tx_ready;

   modport slave (
      input  uart_rx_data, uart_rx_valid, uart_tx_busy,
             core_rx_take, core_tx_enable, core_tx_data,
      output uart_tx_data, uart_tx_write,
             core_rx_valid, core_rx_data, core_tx_ready
   );

   modport master (
      output uart_rx_data, uart_rx_valid, uart_tx_busy,
             core_rx_take, core_tx_enable, core_tx_data,
      input  uart_tx_data, uart_tx_write,
             core_rx_valid, core_rx_data, core_tx_ready
   );
endinterface

// File: rtl/bf2hw_stream_bridge.sv
// ----------------------------------------------------------------------------
// bf2hw_stream_bridge
// Byte-stream buffer between uart_top and a generated kernel core. An RX FIFO
// (first-word fall-through, drop-or-overwrite on overflow) and a TX FIFO
// drained by a small FSM that paces writes against the UART busy handshake.
// Ports:
//   clock_i, reset_i   system clock, asynchronous active-high reset
//   bus                stream handshake bundle (slave side)
//   rx_count_o         RX occupancy
//   tx_count_o         TX occupancy
//   rx_overflow_o      sticky: an RX byte was lost
//   tx_overflow_o      sticky: core pushed while TX full
//   tx_idle_o          TX FIFO empty and TX FSM idle
//
// TX FSM states:
//   state       | meaning
//   S_IDLE      | wait for a buffered byte and UART not busy
//   S_ISSUE     | one-cycle write strobe, head popped
//   S_WAIT_RISE | wait a bounded time for uart_tx_busy to rise
//   S_WAIT_FALL | wait for uart_tx_busy to fall
// ----------------------------------------------------------------------------
module bf2hw_stream_bridge #(
   parameter int DATA_W       = 8,
   parameter int RX_DEPTH     = 16,
   parameter int TX_DEPTH     = 16,
   parameter bit RX_OVERWRITE = 1'b0,
   parameter int BUSY_GUARD   = 2
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   bf2hw_stream_bridge_if.slave      bus,
   output logic [$clog2(RX_DEPTH):0] rx_count_o,
   output logic [$clog2(TX_DEPTH):0] tx_count_o,
   output logic                      rx_overflow_o,
   output logic                      tx_overflow_o,
   output logic                      tx_idle_o
);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_CW = RX_AW + 1;
   localparam int TX_CW = TX_AW + 1;
   // The ISSUE cycle is the first guard cycle, so WAIT_RISE gives up after
   // BUSY_GUARD-1 cycles (never fewer than one).
   localparam int GUARD_LAST = (BUSY_GUARD > 2) ? BUSY_GUARD - 2 : 0;
   localparam int GW         = $clog2(GUARD_LAST + 1) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RISE, S_WAIT_FALL} tx_state_t;

   // ---------------- RX FIFO ----------------
   logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
   logic [RX_AW-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;
   logic              rx_ovf_q, rx_ovf_d;
   logic              rx_full, rx_empty, rx_pop, rx_wr_en, rx_rd_adv;

   assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_pop   = bus.core_rx_take && !rx_empty;

   always_comb begin
      // When full, a same-cycle pop frees the slot; overwrite mode instead
      // steals the oldest slot by advancing the read pointer with the write.
      rx_wr_en  = bus.uart_rx_valid && (!rx_full || rx_pop || RX_OVERWRITE);
      rx_rd_adv = rx_pop || (bus.uart_rx_valid && rx_full && RX_OVERWRITE);
      rx_wr_d   = rx_wr_en  ? rx_wr_q + RX_AW'(1) : rx_wr_q;
      rx_rd_d   = rx_rd_adv ? rx_rd_q + RX_AW'(1) : rx_rd_q;
      rx_cnt_d  = rx_cnt_q;
      if (rx_wr_en && !rx_rd_adv)      rx_cnt_d = rx_cnt_q + RX_CW'(1);
      else if (!rx_wr_en && rx_rd_adv) rx_cnt_d = rx_cnt_q - RX_CW'(1);
      rx_ovf_d = rx_ovf_q || (bus.uart_rx_valid && rx_full && !rx_pop);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
         rx_ovf_q <= 1'b0;
      end else begin
         if (rx_wr_en) rx_mem_q[rx_wr_q] <= bus.uart_rx_data;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         rx_cnt_q <= rx_cnt_d;
         rx_ovf_q <= rx_ovf_d;
      end
   end

   // ---------------- TX FIFO ----------------
   logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
   logic [TX_AW-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
   logic              tx_ovf_q, tx_ovf_d;
   logic              tx_full, tx_empty, tx_push, tx_pop;
   tx_state_t         state_q, state_d;
   logic [GW-1:0]     guard_q, guard_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;

   assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
   assign tx_empty = (tx_cnt_q == '0);
   assign tx_push  = bus.core_tx_enable && !tx_full;
   assign tx_pop   = (state_q == S_ISSUE);

   always_comb begin
      tx_wr_d  = tx_push ? tx_wr_q + TX_AW'(1) : tx_wr_q;
      tx_rd_d  = tx_pop  ? tx_rd_q + TX_AW'(1) : tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + TX_CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TX_CW'(1);
      tx_ovf_d = tx_ovf_q || (bus.core_tx_enable && tx_full);
   end

   // ---------------- TX FSM ----------------
   always_comb begin
      state_d   = state_q;
      guard_d   = guard_q;
      tx_data_d = tx_data_q;
      case (state_q)
         S_IDLE: begin
            if (!tx_empty && !bus.uart_tx_busy) begin
               state_d   = S_ISSUE;
               tx_data_d = tx_mem_q[tx_rd_q];
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_RISE;
            guard_d = '0;
         end
         S_WAIT_RISE: begin
            if (bus.uart_tx_busy)                 state_d = S_WAIT_FALL;
            else if (guard_q == GW'(GUARD_LAST))  state_d = S_IDLE;
            else                                  guard_d = guard_q + GW'(1);
         end
         S_WAIT_FALL: begin
            if (!bus.uart_tx_busy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         tx_cnt_q  <= '0;
         tx_ovf_q  <= 1'b0;
         state_q   <= S_IDLE;
         guard_q   <= '0;
         tx_data_q <= '0;
      end else begin
         if (tx_push) tx_mem_q[tx_wr_q] <= bus.core_tx_data;
         tx_wr_q   <= tx_wr_d;
         tx_rd_q   <= tx_rd_d;
         tx_cnt_q  <= tx_cnt_d;
         tx_ovf_q  <= tx_ovf_d;
         state_q   <= state_d;
         guard_q   <= guard_d;
         tx_data_q <= tx_data_d;
      end
   end

   // ---------------- outputs ----------------
   assign bus.core_rx_valid = !rx_empty;
   assign bus.core_rx_data  = rx_mem_q[rx_rd_q];
   assign bus.core_tx_ready = !tx_full;
   assign bus.uart_tx_write = (state_q == S_ISSUE);
   assign bus.uart_tx_data  = tx_data_q;
   assign rx_count_o        = rx_cnt_q;
   assign tx_count_o        = tx_cnt_q;
   assign rx_overflow_o     = rx_ovf_q;
   assign tx_overflow_o     = tx_ovf_q;
   assign tx_idle_o         = tx_empty && (state_q == S_IDLE);
endmodule

// File: tb/tb_bf2hw_stream_bridge.sv
// ----------------------------------------------------------------------------
// tb_bf2hw_stream_bridge
// Two bridges share one stimulus stream:
//   dut_a : RX_DEPTH=4, RX_OVERWRITE=0, TX_DEPTH=2
//   dut_b : RX_DEPTH=4, RX_OVERWRITE=1, TX_DEPTH=16
// Inputs change and outputs are sampled on the falling clock edge. A small
// UART model drives uart_tx_busy and logs write strobes.
// ----------------------------------------------------------------------------
module tb_bf2hw_stream_bridge;
   logic       clk;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       take;
   logic       tx_en;
   logic [7:0] tx_data;
   logic       busy;

   logic [2:0] a_rx_cnt, b_rx_cnt;
   logic [1:0] a_tx_cnt;
   logic [4:0] b_tx_cnt;
   logic       a_rx_ovf, a_tx_ovf, a_idle;
   logic       b_rx_ovf, b_tx_ovf, b_idle;

   int         n_chk = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         busy_mode = 0;   // 0: busy low, 1: 10-cycle pulse after write, 2: stuck high
   int         busy_cnt = 0;
   logic [7:0] strb_a[$];
   logic [7:0] strb_b[$];
   int         t_a[$];

   bf2hw_stream_bridge_if #(.DATA_W(8)) ifa ();
   bf2hw_stream_bridge_if #(.DATA_W(8)) ifb ();

   assign ifa.uart_rx_data   = rx_data;
   assign ifa.uart_rx_valid  = rx_valid;
   assign ifa.uart_tx_busy   = busy;
   assign ifa.core_rx_take   = take;
   assign ifa.core_tx_enable = tx_en;
   assign ifa.core_tx_data   = tx_data;
   assign ifb.uart_rx_data   = rx_data;
   assign ifb.uart_rx_valid  = rx_valid;
   assign ifb.uart_tx_busy   = busy;
   assign ifb.core_rx_take   = take;
   assign ifb.core_tx_enable = tx_en;
   assign ifb.core_tx_data   = tx_data;

   bf2hw_stream_bridge #(.DATA_W(8), .RX_DEPTH(4), .TX_DEPTH(2),
                         .RX_OVERWRITE(1'b0), .BUSY_GUARD(2)) dut_a (
      .clock_i(clk), .reset_i(rst), .bus(ifa),
      .rx_count_o(a_rx_cnt), .tx_count_o(a_tx_cnt),
      .rx_overflow_o(a_rx_ovf), .tx_overflow_o(a_tx_ovf), .tx_idle_o(a_idle)
   );

   bf2hw_stream_bridge #(.DATA_W(8), .RX_DEPTH(4), .TX_DEPTH(16),
                         .RX_OVERWRITE(1'b1), .BUSY_GUARD(2)) dut_b (
      .clock_i(clk), .reset_i(rst), .bus(ifb),
      .rx_count_o(b_rx_cnt), .tx_count_o(b_tx_cnt),
      .rx_overflow_o(b_rx_ovf), .tx_overflow_o(b_tx_ovf), .tx_idle_o(b_idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (ifa.uart_tx_write) begin
         strb_a.push_back(ifa.uart_tx_data);
         t_a.push_back(cyc);
      end
      if (ifb.uart_tx_write) strb_b.push_back(ifb.uart_tx_data);
      case (busy_mode)
         0: busy = 1'b0;
         2: busy = 1'b1;
         default: begin
            if (busy_cnt > 0) busy_cnt--;
            if (ifa.uart_tx_write) busy_cnt = 10;
            busy = (busy_cnt > 0);
         end
      endcase
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic rx_take();
      take = 1'b1;
      tick();
      take = 1'b0;
   endtask

   task automatic tx_push(input logic [7:0] b);
      tx_data = b; tx_en = 1'b1;
      tick();
      tx_en = 1'b0;
   endtask

   task automatic clear_log();
      strb_a.delete();
      strb_b.delete();
      t_a.delete();
   endtask

   task automatic wait_tx_done(input int na, input int nb);
      for (int i = 0; i < 100; i++) begin
         if (strb_a.size() >= na && strb_b.size() >= nb && a_idle && b_idle) break;
         tick();
      end
      repeat (5) tick();
   endtask

   logic [7:0] exp_full[4];

   initial begin
      rst = 1'b1; rx_data = '0; rx_valid = 1'b0; take = 1'b0;
      tx_en = 1'b0; tx_data = '0; busy = 1'b0;
      repeat (2) tick();

      // ---- reset state ----
      chk_eq("rst_a_rx_cnt",  a_rx_cnt, 0);
      chk_eq("rst_a_rx_vld",  ifa.core_rx_valid, 0);
      chk_eq("rst_a_tx_rdy",  ifa.core_tx_ready, 1);
      chk_eq("rst_a_wr",      ifa.uart_tx_write, 0);
      chk_eq("rst_a_txd",     ifa.uart_tx_data, 0);
      chk_eq("rst_a_flags",   {a_rx_ovf, a_tx_ovf}, 0);
      chk_eq("rst_a_idle",    a_idle, 1);
      chk_eq("rst_b_tx_cnt",  b_tx_cnt, 0);
      rst = 1'b0;
      tick();

      // ---- push + take while empty: take ignored, byte stored ----
      rx_data = 8'h77; rx_valid = 1'b1; take = 1'b1;
      tick();
      rx_valid = 1'b0; take = 1'b0;
      chk_eq("empty_pt_cnt",  a_rx_cnt, 1);
      chk_eq("empty_pt_head", ifa.core_rx_data, 8'h77);
      rx_take();
      chk_eq("empty_pt_vld",  ifa.core_rx_valid, 0);

      // ---- RX ordering ----
      rx_push(8'h41); rx_push(8'h42); rx_push(8'h43);
      chk_eq("ord_a_cnt", a_rx_cnt, 3);
      chk_eq("ord_b_cnt", b_rx_cnt, 3);
      for (int i = 0; i < 3; i++) begin
         chk_eq("ord_a_head", ifa.core_rx_data, 8'h41 + i);
         chk_eq("ord_b_head", ifb.core_rx_data, 8'h41 + i);
         rx_take();
      end
      chk_eq("ord_a_vld", ifa.core_rx_valid, 0);

      // ---- full with simultaneous push + take ----
      for (int i = 0; i < 4; i++) rx_push(8'h01 + 8'(i));
      chk_eq("full_a_cnt", a_rx_cnt, 4);
      rx_data = 8'h55; rx_valid = 1'b1; take = 1'b1;
      tick();
      rx_valid = 1'b0; take = 1'b0;
      chk_eq("fpt_a_cnt", a_rx_cnt, 4);
      chk_eq("fpt_b_cnt", b_rx_cnt, 4);
      chk_eq("fpt_a_ovf", a_rx_ovf, 0);
      chk_eq("fpt_b_ovf", b_rx_ovf, 0);
      exp_full = '{8'h02, 8'h03, 8'h04, 8'h55};
      for (int i = 0; i < 4; i++) begin
         chk_eq("fpt_a_head", ifa.core_rx_data, exp_full[i]);
         chk_eq("fpt_b_head", ifb.core_rx_data, exp_full[i]);
         rx_take();
      end

      // ---- RX overflow: drop (A) vs overwrite (B) ----
      for (int i = 0; i < 5; i++) rx_push(8'h10 + 8'(i));
      chk_eq("ovf_a_cnt", a_rx_cnt, 4);
      chk_eq("ovf_a_flag", a_rx_ovf, 1);
      chk_eq("ovf_b_cnt", b_rx_cnt, 4);
      chk_eq("ovf_b_flag", b_rx_ovf, 1);
      for (int i = 0; i < 4; i++) begin
         chk_eq("ovf_a_head", ifa.core_rx_data, 8'h10 + i);
         chk_eq("ovf_b_head", ifb.core_rx_data, 8'h11 + i);
         rx_take();
      end
      chk_eq("ovf_a_vld", ifa.core_rx_valid, 0);
      chk_eq("ovf_b_vld", ifb.core_rx_valid, 0);

      // ---- TX handshake with 10-cycle busy pulse ----
      busy_mode = 1;
      clear_log();
      tx_push(8'h48); tx_push(8'h69);
      wait_tx_done(2, 2);
      chk_eq("hs_a_nstrb", strb_a.size(), 2);
      chk_eq("hs_b_nstrb", strb_b.size(), 2);
      chk_eq("hs_a_d0", (strb_a.size() > 0) ? strb_a[0] : 8'hee, 8'h48);
      chk_eq("hs_a_d1", (strb_a.size() > 1) ? strb_a[1] : 8'hee, 8'h69);
      chk_eq("hs_after_busy", (t_a.size() > 1) ? ((t_a[1] - t_a[0]) > 10) : 0, 1);
      chk_eq("hs_a_idle", a_idle, 1);

      // ---- TX back-to-back with busy low: 3-cycle spacing ----
      busy_mode = 0;
      clear_log();
      tx_push(8'h01); tx_push(8'h02);
      wait_tx_done(2, 2);
      chk_eq("b2b_nstrb", strb_a.size(), 2);
      chk_eq("b2b_gap", (t_a.size() > 1) ? (t_a[1] - t_a[0]) : 0, 3);
      chk_eq("b2b_hold", ifa.uart_tx_data, 8'h02);

      // ---- TX full with busy stuck high ----
      busy_mode = 2;
      tick();
      clear_log();
      tx_push(8'ha1); tx_push(8'ha2);
      chk_eq("txf_a_rdy", ifa.core_tx_ready, 0);
      chk_eq("txf_b_rdy", ifb.core_tx_ready, 1);
      tx_push(8'ha3);
      chk_eq("txf_a_ovf", a_tx_ovf, 1);
      chk_eq("txf_a_cnt", a_tx_cnt, 2);
      chk_eq("txf_b_ovf", b_tx_ovf, 0);
      chk_eq("txf_b_cnt", b_tx_cnt, 3);
      repeat (5) tick();
      chk_eq("txf_no_strb", strb_a.size(), 0);
      busy_mode = 0;
      wait_tx_done(2, 3);
      chk_eq("txf_a_nstrb", strb_a.size(), 2);
      chk_eq("txf_a_d0", (strb_a.size() > 0) ? strb_a[0] : 8'hee, 8'ha1);
      chk_eq("txf_a_d1", (strb_a.size() > 1) ? strb_a[1] : 8'hee, 8'ha2);
      chk_eq("txf_b_nstrb", strb_b.size(), 3);
      chk_eq("txf_b_d2", (strb_b.size() > 2) ? strb_b[2] : 8'hee, 8'ha3);
      chk_eq("txf_a_idle", a_idle, 1);

      // ---- reset mid-stream ----
      busy_mode = 2;
      tick();
      for (int i = 0; i < 5; i++) rx_push(8'h30 + 8'(i));
      for (int i = 0; i < 3; i++) tx_push(8'h60 + 8'(i));
      chk_eq("mid_pre_a_cnt", a_tx_cnt, 2);
      #2 rst = 1'b1;
      #1;
      chk_eq("mid_a_rx_cnt", a_rx_cnt, 0);
      chk_eq("mid_b_rx_cnt", b_rx_cnt, 0);
      chk_eq("mid_a_tx_cnt", a_tx_cnt, 0);
      chk_eq("mid_b_tx_cnt", b_tx_cnt, 0);
      chk_eq("mid_a_vld",    ifa.core_rx_valid, 0);
      chk_eq("mid_a_idle",   a_idle, 1);
      chk_eq("mid_a_flags",  {a_rx_ovf, a_tx_ovf}, 0);
      busy_mode = 0;
      clear_log();
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk_eq("mid_no_strb_a", strb_a.size(), 0);
      chk_eq("mid_no_strb_b", strb_b.size(), 0);
      chk_eq("mid_b_idle", b_idle, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/bf2hw_stream_bridge.md
Name: bf2hw_stream_bridge

Overview:
Parametrised byte-stream buffer between the UART (uart_top) and a generated kernel core (main_*_interface).
- Adds an RX FIFO and a TX FIFO with configurable depth and width, plus a selectable RX overflow policy.
- Sequences TX writes against the UART busy handshake; reports fill levels and sticky overflow flags.
- Instantiated once per channel in the top level, after the reset synchronizer.

Parameters:
DATA_W, 8, byte width on UART and core sides
RX_DEPTH, 16, RX FIFO entries; power of two, >=2
TX_DEPTH, 16, TX FIFO entries; power of two, >=2
RX_OVERWRITE, 0, 0 = drop incoming byte when RX full; 1 = overwrite oldest entry
BUSY_GUARD, 2, cycles to wait for uart_tx_busy to rise after a write before treating the byte as sent

Ports:
clock  in  1  system clock (single domain)
reset  in  1  asynchronous, active-high reset
uart_rx_data  in  DATA_W  received byte
uart_rx_valid  in  1  one-cycle strobe, uart_rx_data valid
uart_tx_data  out  DATA_W  byte to transmit
uart_tx_write  out  1  one-cycle write strobe to UART
uart_tx_busy  in  1  UART transmitter busy
core_rx_valid  out  1  RX FIFO non-empty
core_rx_data  out  DATA_W  RX FIFO head (first-word fall-through)
core_rx_take  in  1  pop RX head; ignored when core_rx_valid=0
core_tx_enable  in  1  push core_tx_data into TX FIFO
core_tx_data  in  DATA_W  byte from core
core_tx_ready  out  1  TX FIFO not full
rx_count  out  clog2(RX_DEPTH)+1  RX occupancy
tx_count  out  clog2(TX_DEPTH)+1  TX occupancy
rx_overflow  out  1  sticky: an RX byte was lost
tx_overflow  out  1  sticky: core pushed while TX full
tx_idle  out  1  TX FIFO empty and TX FSM in IDLE

Behaviour:
Reset:
- Async assert; all state cleared. Both FIFOs empty; counts 0.
- core_rx_valid=0, core_tx_ready=1, uart_tx_write=0, uart_tx_data=0.
- Flags 0, tx_idle=1, TX FSM=IDLE.
- Reset mid-transfer discards all buffered data. No write strobe is emitted in the cycle reset deasserts.

RX path:
- uart_rx_valid at edge N writes the FIFO; core_rx_valid=1 and data visible after edge N (1-cycle latency).
- core_rx_take with valid=1 pops; the next head is visible the following cycle.
- Push+pop in the same cycle: occupancy unchanged, both succeed, including when full (no overflow).
- Push when full without a pop:
  - RX_OVERWRITE=0: byte dropped, rx_overflow set.
  - RX_OVERWRITE=1: oldest entry discarded, new byte written, rx_count stays RX_DEPTH, rx_overflow set.
- Push and take while empty: the take is ignored; the byte is stored.
- Pointers wrap modulo depth; counts saturate at depth.

TX path:
- core_tx_enable with core_tx_ready=1 pushes.
- core_tx_enable when full: byte dropped, tx_overflow set, FIFO unchanged.
- A push and a FSM pop in the same cycle are both allowed.

TX FSM:
- IDLE: if FIFO non-empty and uart_tx_busy=0, go to ISSUE.
- ISSUE (1 cycle): uart_tx_write=1, uart_tx_data=head, pop head, go to WAIT_RISE. guard counter=0.
- WAIT_RISE: if busy=1, go to WAIT_FALL; else increment the guard counter. At BUSY_GUARD, go to IDLE.
- WAIT_FALL: when busy=0, go to IDLE.
- Minimum spacing between write strobes is 3 cycles. uart_tx_data holds its value until the next ISSUE.

Flags: rx_overflow and tx_overflow clear only on reset.

Test Plan:
- Reset mid-stream: 5 bytes in RX, 3 in TX, assert reset asynchronously -> counts 0, core_rx_valid=0, tx_idle=1, no uart_tx_write after release.
- RX ordering: strobe 0x41,0x42,0x43 with core_rx_take=0 -> rx_count=3, head 0x41. Take 3 times -> 0x41,0x42,0x43 in order, then valid=0.
- RX overflow, DEPTH=4, RX_OVERWRITE=0: push 0x10..0x14 -> rx_count=4, rx_overflow=1, pops yield 0x10..0x13.
  Same with RX_OVERWRITE=1 -> pops yield 0x11..0x14.
- RX full with simultaneous push 0x55 and take -> rx_count stays 4, rx_overflow=0, 0x55 is the last byte out.
- TX handshake: push 0x48,0x69. UART model raises busy 1 cycle after a write for 10 cycles -> exactly 2 write strobes carrying 0x48 then 0x69. Second strobe only after busy falls.
  Busy held 0 -> strobes 3 cycles apart.
- TX full, TX_DEPTH=2, busy stuck 1: push 3 bytes -> core_tx_ready=0 after the 2nd, tx_overflow=1, tx_count=2, no strobes.
  Release busy -> 2 strobes, tx_idle=1.
